// File: rtl/uart_xmit_arb.sv
// Two-requester arbiter/sequencer in front of the shared UART byte transmitter.
// Define UART_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.
module uart_xmit_arb #(
  parameter int unsigned     TO_W           = 10,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 10'd400
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic       req0H,
  input  logic [7:0] data0H,
  output logic       ack0H,
  input  logic       req1H,
  input  logic [7:0] data1H,
  output logic       ack1H,
  output logic       xmitH,
  output logic [7:0] xmit_dataH,
  input  logic       xmit_doneH,
  output logic       busyH,
  output logic       gnt_idH,
  output logic       err_toH
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - TO_W'(1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            gnt_q, gnt_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic            xmit_q, xmit_d, busy_q, busy_d, err_q, err_d;
  logic            win1;

`ifdef UART_ARB_RR_EN
  // last_q holds the id granted most recently; reset to 1 so requester 0 takes the first tie
  logic last_q, last_d;
  always_comb win1 = (req0H && req1H) ? ~last_q : req1H;
`else
  always_comb win1 = req1H && !req0H;
`endif

  // Registered outputs are decoded from the next state, so each pulse lines up with its state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    xmit_d  = 1'b0;
    err_d   = 1'b0;
`ifdef UART_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0H || req1H) begin
          state_d = S_LOAD;
          gnt_d   = win1;
          data_d  = win1 ? data1H : data0H;
          ack0_d  = ~win1;
          ack1_d  = win1;
`ifdef UART_ARB_RR_EN
          last_d  = win1;
`endif
        end
      end
      S_LOAD: begin
        state_d = S_START;
        xmit_d  = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // done wins over a timeout expiring in the same cycle
        if (xmit_doneH) begin
          state_d = S_IDLE;
        end else if ((TIMEOUT_CYCLES != '0) && (cnt_q == TO_LAST)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      xmit_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      xmit_q  <= xmit_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef UART_ARB_RR_EN
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) last_q <= 1'b1;
    else            last_q <= last_d;
  end
`endif

  assign ack0H      = ack0_q;
  assign ack1H      = ack1_q;
  assign xmitH      = xmit_q;
  assign xmit_dataH = data_q;
  assign busyH      = busy_q;
  assign gnt_idH    = gnt_q;
  assign err_toH    = err_q;

endmodule
